// File: rtl/div_unit_if.sv
// Operand/request and result/status bundle between the EX stage and div_unit.
// The master drives operands and requests. The slave returns the result, ready and stall.
interface div_unit_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_div;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  modport master (
    output a, b, signed_div, start, annul,
    input  result, ready, stall
  );

  modport slave (
    input  a, b, signed_div, start, annul,
    output result, ready, stall
  );
endinterface

// File: rtl/div_unit.sv
// 32-bit DIV/DIVU restoring divider producing {remainder, quotient}; ready 33 cycles after accept (2 for /0).
// No backpressure: stall freezes the pipeline while busy, and annul aborts the operation at any point.
module div_unit (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIVZERO = 2'd1;
  localparam logic [1:0] ON      = 2'd2;
  localparam logic [1:0] END     = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;
  logic [63:0] pend;
  logic [63:0] res_q;

  logic        accept;
  logic        last_iter;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] trial;
  logic        trial_ge;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] rem_fix;
  logic [31:0] quo_fix;

  assign accept    = (state == IDLE) & bus.start & ~bus.annul;
  assign last_iter = (state == ON) & (cnt == 5'd31);

  // 0x80000000 negates to itself, which is exactly the unsigned magnitude 2^31.
  assign mag_a = (bus.signed_div & bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign mag_b = (bus.signed_div & bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

  assign trial    = {rem, quo[31]};
  assign trial_ge = trial >= {1'b0, dvs};

  always_comb begin
    rem_nxt = trial[31:0];
    quo_nxt = {quo[30:0], 1'b0};
    if (trial_ge) begin
      rem_nxt = trial[31:0] - dvs;
      quo_nxt = {quo[30:0], 1'b1};
    end
  end

  assign rem_fix = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;
  assign quo_fix = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (bus.b == 32'd0) ? DIVZERO : ON;
        end
      end
      DIVZERO: state_nxt = END;
      ON: begin
        if (cnt == 5'd31) begin
          state_nxt = END;
        end
      end
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.annul) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      rem   <= 32'd0;
      quo   <= 32'd0;
      dvs   <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      pend  <= 64'd0;
      res_q <= 64'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dvs   <= mag_b;
        quo   <= mag_a;
        rem   <= 32'd0;
        cnt   <= 5'd0;
        neg_q <= bus.signed_div & (bus.a[31] ^ bus.b[31]);
        neg_r <= bus.signed_div & bus.a[31];
      end else if (state == ON) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + 5'd1;
      end
      // The corrected result is staged so an annul in END can still discard it.
      if (last_iter && !bus.annul) begin
        pend <= {rem_fix, quo_fix};
      end
      if (state == DIVZERO && !bus.annul) begin
        pend <= 64'd0;
      end
      if (state == END && !bus.annul) begin
        res_q <= pend;
      end
    end
  end

  assign bus.ready  = (state == END) & ~bus.annul;
  assign bus.result = bus.ready ? pend : res_q;
  assign bus.stall  = rst & ~bus.annul &
                      (((state == IDLE) & bus.start) | (state == ON) | (state == DIVZERO));

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a negedge monitor pops on ready.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_unit_if bus();

  div_unit dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];
  logic        prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.ready === 1'b1) begin
      check64("ready_width", {63'd0, prev_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: got result %h with no request outstanding", bus.result);
      end else begin
        check64("result", bus.result, exp_q.pop_front());
      end
    end
    prev_ready = (bus.ready === 1'b1);
  end

  task automatic do_div(input string nm, input logic [31:0] da, input logic [31:0] db,
                        input logic ds, input logic [63:0] exp, input int lat, output int rc);
    int c0;
    int got;
    int stall_bad;
    @(posedge clk);
    #1;
    bus.a = da;
    bus.b = db;
    bus.signed_div = ds;
    bus.start = 1'b1;
    exp_q.push_back(exp);
    c0 = cyc;
    got = -1;
    stall_bad = 0;
    for (int k = 0; k <= lat + 3; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        if (k == 1) begin
          bus.start = 1'b0;
          bus.a = ~da;
          bus.b = da ^ 32'h5a5a_0001;
          bus.signed_div = ~ds;
        end
      end
      @(negedge clk);
      if (bus.stall !== ((k < lat) ? 1'b1 : 1'b0)) stall_bad++;
      if (bus.ready === 1'b1) begin
        got = k;
        break;
      end
    end
    check_int({nm, "_latency"}, got, lat);
    check_int({nm, "_stall_bad_cycles"}, stall_bad, 0);
    rc = c0 + got;
  endtask

  task automatic count_ready(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int rc1;
    int rc2;
    int n;

    rst_n = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.signed_div = 1'b0;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    #2 bus.start = 1'b1;
    #1;
    check64("reset_result", bus.result, 64'd0);
    check64("reset_ready", {63'd0, bus.ready}, 64'd0);
    check64("reset_stall", {63'd0, bus.stall}, 64'd0);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_div("divu_100_7",   32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 33, rc);
    do_div("div_m7_2",     32'hFFFFFFF9,   32'h00000002,   1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, rc);
    do_div("div_7_m2",     32'h00000007,   32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD, 33, rc);
    do_div("div_min_m1",   32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000, 33, rc);
    do_div("divu_max_1",   32'hFFFFFFFF,   32'h00000001,   1'b0, 64'h00000000_FFFFFFFF, 33, rc);
    do_div("divu_by_zero", 32'h00001234,   32'h00000000,   1'b0, 64'h0,                  2, rc);
    do_div("divu_5_9",     32'd5,          32'd9,          1'b0, 64'h00000005_00000000, 33, rc);

    // Annul in cycle 10 of DIVU 100/7.
    @(posedge clk);
    #1;
    bus.a = 32'd100;
    bus.b = 32'd7;
    bus.signed_div = 1'b0;
    bus.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.start = 1'b0;
    end
    bus.annul = 1'b1;
    #1;
    check64("annul_stall", {63'd0, bus.stall}, 64'd0);
    @(posedge clk);
    #1 bus.annul = 1'b0;
    #1;
    check64("annul_idle_stall", {63'd0, bus.stall}, 64'd0);
    count_ready(40, n);
    check_int("annul_ready_count", n, 0);
    check64("annul_result_kept", bus.result, 64'h00000005_00000000);

    do_div("divu_9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, rc);

    // start and annul together in IDLE: nothing accepted.
    @(posedge clk);
    #1;
    bus.a = 32'd8;
    bus.b = 32'd2;
    bus.start = 1'b1;
    bus.annul = 1'b1;
    #1;
    check64("start_annul_stall", {63'd0, bus.stall}, 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    count_ready(40, n);
    check_int("start_annul_ready_count", n, 0);
    check64("start_annul_result", bus.result, 64'h00000000_00000003);

    // Asynchronous reset in cycle 15 of an operation.
    @(posedge clk);
    #1;
    bus.a = 32'd100;
    bus.b = 32'd7;
    bus.start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    bus.start = 1'b1;
    #1;
    check64("midop_reset_result", bus.result, 64'd0);
    check64("midop_reset_ready", {63'd0, bus.ready}, 64'd0);
    check64("midop_reset_stall", {63'd0, bus.stall}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.start = 1'b0;
    count_ready(40, n);
    check_int("midop_reset_ready_count", n, 0);

    // Back-to-back: second start in the cycle right after END.
    do_div("b2b_first",  32'hFFFFFFF9, 32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, rc1);
    do_div("b2b_second", 32'h00000007, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, rc2);
    check_int("b2b_ready_spacing", rc2 - rc1, 34);

    repeat (3) @(posedge clk);
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider that produces the 64-bit `div_res` word the ALU writes into HI/LO for DIV and DIVU. It sits beside the ALU in the execute stage. It latches operands on `start`, stalls the pipeline through a 32-iteration restoring division, and presents `{remainder, quotient}` with a one-cycle `ready` pulse.

## Interface
- No parameters; the datapath width is fixed at 32 bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `a`  in  32  dividend (rs).
- `b`  in  32  divisor (rt).
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `start`  in  1  request; asserted while alucontrol is DIV/DIVU in EX.
- `annul`  in  1  flush request (exception/flush of EX); aborts any operation.
- `result`  out  64  `{remainder[31:0], quotient[31:0]}`; maps to `{hi_out, lo_out}`.
- `ready`  out  1  one-cycle pulse; `result` is valid from this cycle on.
- `stall`  out  1  freezes IF/ID/EX while the division is in progress.

## Operation
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - `start`=1 and `annul`=0 latch `a`, `b` and `signed_div`, and clear the iteration counter.
  - `b`==0 → DIVZERO; otherwise → ON.
- Latched operands are used for the whole operation. Later changes on `a`/`b`/`signed_div` are ignored.
- Signed mode:
  - Operate on the magnitudes |a| and |b|. 0x80000000 is treated as the unsigned value 2^31.
  - Quotient is negated if sign(a) ≠ sign(b).
  - Remainder takes the sign of `a`.
- ON, restoring division:
  - Each cycle, shift `{rem, quo}` left by 1 and trial-subtract the divisor from the upper 33 bits.
  - If the difference is non-negative, keep it and set the quotient LSB to 1; otherwise restore the upper bits and set the LSB to 0.
  - The counter runs 0..31; after iteration 31 → END.
- DIVZERO: lasts one cycle, then → END with `result` = 64'h0 (defined value; the architecture leaves it unpredictable).
- END:
  - Register the sign-corrected `result`, pulse `ready`=1, then → IDLE.
  - `start` is ignored in END.
- `result` holds its last value until the next accepted `start`; it is not cleared on return to IDLE.
- `stall` = (IDLE & `start`) | ON | DIVZERO, forced to 0 when `annul`=1. `stall` is 0 in END, so the pipeline advances on the edge that ends the `ready` cycle.
- `annul`=1 in any state:
  - Next state is IDLE and `ready` is not pulsed.
  - A pending or partial result is discarded; `result` keeps its previous value.
- Back-to-back divides: a new `start` seen in IDLE on the cycle after END is accepted normally.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `result`=64'h0, `ready`=0, counter=0. `stall` is forced to 0 while `rst`=0.
- Reset released mid-operation: the block restarts from IDLE. The pending instruction re-requests through `start`.
- Cycle numbering: the accept edge ends cycle 0.
  - Normal divide: ON for cycles 1–32, END (`ready`=1) in cycle 33. `stall`=1 in cycles 0–32.
  - Divide by zero: DIVZERO in cycle 1, `ready`=1 in cycle 2.
- `ready` is exactly one cycle wide and never asserts without a prior accepted `start`.
- `start` and `annul` in the same IDLE cycle: `annul` wins, nothing is latched, `stall`=0.

## Test plan
- DIVU 100/7: `start` in cycle 0 → `stall`=1 in cycles 0–32; `ready` only in cycle 33; `result`=64'h00000002_0000000E.
- DIV −7/2 (0xFFFFFFF9 / 0x00000002) → `result`=64'hFFFFFFFF_FFFFFFFD (remainder −1, quotient −3). Also check DIV 7/−2 → 64'h00000001_FFFFFFFD.
- Boundary operands:
  - DIV 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000.
  - DIVU 0xFFFFFFFF / 1 → 64'h00000000_FFFFFFFF.
  - DIVU 5/9 → 64'h00000005_00000000.
- Divide by zero: DIVU 0x1234/0 → `ready` in cycle 2, `result`=64'h0, `stall` low from cycle 2.
- `annul` in cycle 10 of a DIVU 100/7 → IDLE in cycle 11, no `ready`, `result` unchanged. Then a new DIVU 9/3 → `ready` in its cycle 33, `result`=64'h00000000_00000003.
- `rst` driven low in cycle 15 of an operation → outputs are at reset values immediately. Also run two back-to-back DIVs (`start` re-asserted the cycle after END): two `ready` pulses 34 cycles apart, each with the correct `result`.
